// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer
// Front-end sequencer for the combinational calculator ALU. Operand 1, operand 2
// and the op code are entered from switches in three button-stepped phases and
// held in registers that feed the ALU; the ALU result and flags are then
// captured for display.
//
// Optional feature: define CALC_SEQ_DEBOUNCE_EN to insert a per-button
// debouncer (DEBOUNCE_CYCLES stable cycles) between synchronizer and edge
// detector. Without it the synchronized level drives the edge detector.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   sw[N]             operand switches
//   op_sw[4]          operation-code switches
//   btn_next          step button (async, active-high)
//   btn_clear         clear button (async, active-high)
//   alu_op_select[4]  registered op code to ALU
//   alu_operand1[N]   registered operand 1 to ALU
//   alu_operand2[N]   registered operand 2 to ALU
//   alu_resultado[2N] ALU result
//   alu_banderas[4]   ALU flags
//   result_q[2N]      captured result
//   flags_q[4]        captured flags
//   result_valid      capture held valid
//   phase[3]          one-hot LED phase (001 A, 010 B, 100 OP, 000 EXEC/SHOW)
//
// state   | meaning
// LOAD_A  | waiting for step to latch operand 1
// LOAD_B  | waiting for step to latch operand 2
// LOAD_OP | waiting for step to latch op code
// EXEC    | one settle cycle, capture ALU outputs at its end
// SHOW    | result displayed, step returns to LOAD_A

module calc_input_sequencer #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   sw,
   input  logic [3:0]     op_sw,
   input  logic           btn_next,
   input  logic           btn_clear,
   output logic [3:0]     alu_op_select,
   output logic [N-1:0]   alu_operand1,
   output logic [N-1:0]   alu_operand2,
   input  logic [2*N-1:0] alu_resultado,
   input  logic [3:0]     alu_banderas,
   output logic [2*N-1:0] result_q,
   output logic [3:0]     flags_q,
   output logic           result_valid,
   output logic [2:0]     phase
);

   typedef enum logic [2:0] {
      S_LOAD_A  = 3'd0,
      S_LOAD_B  = 3'd1,
      S_LOAD_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_SHOW    = 3'd4
   } state_t;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("calc_input_sequencer: DEBOUNCE_CYCLES must be at least 2");
   end

   // bit 0 = next, bit 1 = clear
   logic [1:0] btn_raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] btn_lvl;
   logic [1:0] btn_prev;
   logic       step_pulse;
   logic       clear_pulse;

   assign btn_raw = {btn_clear, btn_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

`ifdef CALC_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   for (genvar g = 0; g < 2; g++) begin : g_deb
      logic [CW-1:0] deb_cnt;

      // Down-counter runs only while the input disagrees with the debounced
      // level; agreement (a bounce back) reloads it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb_cnt    <= DEB_LOAD;
            btn_lvl[g] <= 1'b0;
         end else if (sync2[g] == btn_lvl[g]) begin
            deb_cnt <= DEB_LOAD;
         end else if (deb_cnt == '0) begin
            btn_lvl[g] <= sync2[g];
            deb_cnt    <= DEB_LOAD;
         end else begin
            deb_cnt <= deb_cnt - 1'b1;
         end
      end
   end
`else
   assign btn_lvl = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_prev <= '0;
      else        btn_prev <= btn_lvl;
   end

   assign step_pulse  = btn_lvl[0] & ~btn_prev[0];
   assign clear_pulse = btn_lvl[1] & ~btn_prev[1];

   state_t state, state_nxt;
   logic   ld_a, ld_b, ld_op, capture, drop_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LOAD_A;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      ld_op      = 1'b0;
      capture    = 1'b0;
      drop_valid = 1'b0;
      if (clear_pulse) begin
         state_nxt = S_LOAD_A;
      end else begin
         case (state)
            S_LOAD_A:  if (step_pulse) begin ld_a  = 1'b1; state_nxt = S_LOAD_B;  end
            S_LOAD_B:  if (step_pulse) begin ld_b  = 1'b1; state_nxt = S_LOAD_OP; end
            S_LOAD_OP: if (step_pulse) begin ld_op = 1'b1; state_nxt = S_EXEC;    end
            S_EXEC:    begin capture = 1'b1; state_nxt = S_SHOW; end
            S_SHOW:    if (step_pulse) begin drop_valid = 1'b1; state_nxt = S_LOAD_A; end
            default:   state_nxt = S_LOAD_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_operand1  <= '0;
         alu_operand2  <= '0;
         alu_op_select <= '0;
         result_q      <= '0;
         flags_q       <= '0;
         result_valid  <= 1'b0;
      end else if (clear_pulse) begin
         alu_operand1  <= '0;
         alu_operand2  <= '0;
         alu_op_select <= '0;
         result_q      <= '0;
         flags_q       <= '0;
         result_valid  <= 1'b0;
      end else begin
         if (ld_a)  alu_operand1  <= sw;
         if (ld_b)  alu_operand2  <= sw;
         if (ld_op) alu_op_select <= op_sw;
         if (capture) begin
            result_q     <= alu_resultado;
            flags_q      <= alu_banderas;
            result_valid <= 1'b1;
         end else if (drop_valid) begin
            result_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      phase = 3'b000;
      case (state)
         S_LOAD_A:  phase = 3'b001;
         S_LOAD_B:  phase = 3'b010;
         S_LOAD_OP: phase = 3'b100;
         default:   phase = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_calc_input_sequencer.sv
module tb_calc_input_sequencer;

   localparam int N = 4;
`ifdef CALC_SEQ_DEBOUNCE_EN
   localparam int DEB = 16;
`else
   localparam int DEB = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   sw = '0;
   logic [3:0]     op_sw = '0;
   logic           btn_next = 1'b0;
   logic           btn_clear = 1'b0;
   logic [3:0]     alu_op_select;
   logic [N-1:0]   alu_operand1;
   logic [N-1:0]   alu_operand2;
   logic [2*N-1:0] alu_resultado;
   logic [3:0]     alu_banderas;
   logic [2*N-1:0] result_q;
   logic [3:0]     flags_q;
   logic           result_valid;
   logic [2:0]     phase;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calc_input_sequencer #(.N(N), .DEBOUNCE_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sw            (sw),
      .op_sw         (op_sw),
      .btn_next      (btn_next),
      .btn_clear     (btn_clear),
      .alu_op_select (alu_op_select),
      .alu_operand1  (alu_operand1),
      .alu_operand2  (alu_operand2),
      .alu_resultado (alu_resultado),
      .alu_banderas  (alu_banderas),
      .result_q      (result_q),
      .flags_q       (flags_q),
      .result_valid  (result_valid),
      .phase         (phase)
   );

   // Small ALU stand-in: add, multiply, otherwise zero; flags {0, >0x0F, 0, zero}
   always_comb begin
      alu_resultado = '0;
      case (alu_op_select)
         4'b0000: alu_resultado = {4'b0, alu_operand1} + {4'b0, alu_operand2};
         4'b0010: alu_resultado = {4'b0, alu_operand1} * {4'b0, alu_operand2};
         default: alu_resultado = '0;
      endcase
      alu_banderas = {1'b0, alu_resultado > 8'h0F, 1'b0, alu_resultado == 8'h00};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic press_next(input logic [N-1:0] val);
      @(negedge clk);
      sw = val;
      btn_next = 1'b1;
      repeat (4 + DEB) @(negedge clk);
      btn_next = 1'b0;
      repeat (3 + DEB) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_op"},  32'(alu_op_select), 32'h0);
      chk({tag, "_a"},   32'(alu_operand1),  32'h0);
      chk({tag, "_b"},   32'(alu_operand2),  32'h0);
      chk({tag, "_res"}, 32'(result_q),      32'h0);
      chk({tag, "_flg"}, 32'(flags_q),       32'h0);
      chk({tag, "_vld"}, 32'(result_valid),  32'h0);
      chk({tag, "_ph"},  32'(phase),         32'h1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_outputs_zero("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // add 3 + 5 with exact capture timing on the third step
      press_next(4'd3);
      chk("a_ph", 32'(phase), 32'h2);
      chk("a_val", 32'(alu_operand1), 32'h3);
      press_next(4'd5);
      chk("b_ph", 32'(phase), 32'h4);
      chk("b_val", 32'(alu_operand2), 32'h5);
      @(negedge clk);
      op_sw = 4'b0000;
      btn_next = 1'b1;
      repeat (2 + DEB) @(negedge clk);
      chk("op_wait_ph", 32'(phase), 32'h4);
      @(negedge clk);
      chk("exec_ph", 32'(phase), 32'h0);
      chk("exec_vld", 32'(result_valid), 32'h0);
      @(negedge clk);
      chk("show_vld", 32'(result_valid), 32'h1);
      chk("add_res", 32'(result_q), 32'h08);
      chk("add_flg", 32'(flags_q), 32'h0);
      repeat (2 + DEB) @(negedge clk);
      btn_next = 1'b0;
      repeat (3 + DEB) @(negedge clk);
      chk("held_show_vld", 32'(result_valid), 32'h1);

      // leave SHOW, then multiply 7 * 6
      press_next(4'd0);
      chk("ack_vld", 32'(result_valid), 32'h0);
      chk("ack_ph", 32'(phase), 32'h1);
      press_next(4'd7);
      press_next(4'd6);
      op_sw = 4'b0010;
      press_next(4'd0);
      chk("mul_vld", 32'(result_valid), 32'h1);
      chk("mul_res", 32'(result_q), 32'h2A);
      chk("mul_flg", 32'(flags_q), 32'h4);
      chk("mul_op", 32'(alu_op_select), 32'h2);
      press_next(4'd0);
      chk("mul_ack_vld", 32'(result_valid), 32'h0);
      chk("mul_ack_ph", 32'(phase), 32'h1);

      // long hold: exactly one advance, operand captured once
      @(negedge clk);
      sw = 4'd9;
      btn_next = 1'b1;
      repeat (10) @(negedge clk);
      sw = 4'd1;
      repeat (40) @(negedge clk);
      btn_next = 1'b0;
      repeat (3 + DEB) @(negedge clk);
      chk("hold_ph", 32'(phase), 32'h2);
      chk("hold_a", 32'(alu_operand1), 32'h9);

      // clear and step together in LOAD_OP; result_q still holds 0x2A before this
      press_next(4'd4);
      chk("pre_clr_ph", 32'(phase), 32'h4);
      @(negedge clk);
      op_sw = 4'b0101;
      btn_next = 1'b1;
      btn_clear = 1'b1;
      repeat (4 + DEB) @(negedge clk);
      btn_next = 1'b0;
      btn_clear = 1'b0;
      repeat (3 + DEB) @(negedge clk);
      check_outputs_zero("clr");

      // async reset in LOAD_B, observed before the next rising edge
      press_next(4'd6);
      chk("pre_rst_a", 32'(alu_operand1), 32'h6);
      chk("pre_rst_ph", 32'(phase), 32'h2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("arst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      press_next(4'd2);
      chk("post_rst_a", 32'(alu_operand1), 32'h2);
      chk("post_rst_ph", 32'(phase), 32'h2);

`ifdef CALC_SEQ_DEBOUNCE_EN
      // 3-cycle glitches never survive the debouncer
      for (int i = 0; i < 4; i++) begin
         btn_next = 1'b1;
         repeat (3) @(negedge clk);
         btn_next = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (30) @(negedge clk);
      chk("glitch_ph", 32'(phase), 32'h2);
      // 20-cycle press: step accepted at 2+16 cycles
      sw = 4'd11;
      btn_next = 1'b1;
      repeat (2 + 16) @(negedge clk);
      chk("deb_wait_ph", 32'(phase), 32'h2);
      @(negedge clk);
      chk("deb_step_ph", 32'(phase), 32'h4);
      chk("deb_step_b", 32'(alu_operand2), 32'hB);
      @(negedge clk);
      btn_next = 1'b0;
      repeat (30) @(negedge clk);
      chk("deb_once_ph", 32'(phase), 32'h4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_input_sequencer.md
# calc_input_sequencer

Sequential front-end that drives the combinational calculator ALU from board switches and a push-button. It collects operand 1, operand 2 and the 4-bit operation code in three button-stepped phases, presents them as registered, stable inputs to the ALU, then captures the ALU result and flags into holding registers for display. The calculator is purely combinational; this block is the initiator that sequences and registers its inputs and outputs.

## Interface
Parameters:
- N, 4, operand width; ALU result width is 2*N.
- DEBOUNCE_CYCLES, 16, stable-cycle count for button debounce (used only with CALC_SEQ_DEBOUNCE_EN); minimum 2.

Ports:
- clk  in  1  single system clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  N  operand switches, sampled on an accepted step.
- op_sw  in  4  operation-code switches, sampled on an accepted step.
- btn_next  in  1  step button, asynchronous, active-high.
- btn_clear  in  1  clear button, asynchronous, active-high.
- alu_op_select  out  4  registered op code to the ALU.
- alu_operand1  out  N  registered operand 1 to the ALU.
- alu_operand2  out  N  registered operand 2 to the ALU.
- alu_resultado  in  2N  ALU result.
- alu_banderas  in  4  ALU flags.
- result_q  out  2N  captured result.
- flags_q  out  4  captured flags.
- result_valid  out  1  high while result_q/flags_q hold a valid capture.
- phase  out  3  one-hot phase indicator for LEDs: 001 LOAD_A, 010 LOAD_B, 100 LOAD_OP; 000 in EXEC/SHOW.

## Operation
- Both buttons pass a 2-flop synchronizer; a rising-edge detector on the synchronized (optionally debounced) level produces single-cycle step and clear pulses. A held button yields exactly one pulse.
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW.
- LOAD_A + step: alu_operand1 <= sw; go LOAD_B.
- LOAD_B + step: alu_operand2 <= sw; go LOAD_OP.
- LOAD_OP + step: alu_op_select <= op_sw; go EXEC.
- EXEC: unconditional one-cycle settle; result_q <= alu_resultado, flags_q <= alu_banderas, result_valid <= 1; go SHOW.
- SHOW + step: result_valid <= 0; go LOAD_A. Operand/op registers keep values until overwritten.
- Clear pulse in any state: all registers to reset values, state LOAD_A. Clear has priority over a simultaneous step.
- Step pulses arriving during EXEC are ignored.
- Reset values: state LOAD_A, alu_op_select 0, alu_operand1 0, alu_operand2 0, result_q 0, flags_q 0, result_valid 0, phase 001; synchronizer/debounce state 0.
- Asynchronous reset mid-sequence discards any partial entry; no capture occurs.

## Timing
- Without debounce: button rising before edge k -> pulse during cycle after edge k+1 -> register update at edge k+2.
- With debounce: pulse additionally delayed by DEBOUNCE_CYCLES cycles of stable synchronized level.
- ALU inputs change only on accepted steps; they are stable for the whole EXEC cycle.
- result_valid rises at the edge ending EXEC, i.e. one cycle after the LOAD_OP step is accepted.
- Outputs are all registered except phase (decoded from state register).

## Configuration
- CALC_SEQ_DEBOUNCE_EN defined: per-button counter; debounced level toggles only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
- Not defined: synchronized level feeds the edge detector directly; DEBOUNCE_CYCLES unused.

## Test plan
- N=4, macro off: sw=3 step, sw=5 step, op_sw=0000 step, ALU model add -> result_q=8'h08, result_valid=1 one cycle after third accepted step.
- Multiply: A=7, B=6, op=0010 -> result_q=8'h2A; fourth step clears result_valid, phase=001.
- btn_next held 50 cycles in LOAD_A -> single advance to LOAD_B, operand1 captured once.
- btn_clear and btn_next rise together in LOAD_OP -> state LOAD_A, all outputs zero, op not captured.
- rst_n pulsed low in LOAD_B asynchronously -> all outputs at reset values immediately, before next clk edge.
- Macro on, DEBOUNCE_CYCLES=16: 3-cycle glitches on btn_next -> no step; 20-cycle stable press -> one step at 2+16 cycles latency.
